fp_operand_unpack: RTL and testbench
====================================

# fp_operand_unpack

Streaming operand unpacker between the operand SRAM read port and the west/north edge feeders of the systolic array. It accepts 16-bit packed words holding either two FP8 elements (E4M3 or E5M2) or one BF16 element, and decodes each element into a common unbiased sign/exponent/significand form with class flags. PEs therefore never handle format-specific bias or special encodings. Flow control is valid/ready on both sides, with one registered output stage and a one-element pending buffer for the second FP8 byte.

## Interface
- No parameters; widths are fixed by the formats in `fp_formats_pkg`.
- `clk` in, 1: single clock.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `clear` in, 1: synchronous clear of the status counter and sticky flags only; datapath state is untouched.
- `mode` in, 2 (`fp_mode_e`): format of `in_data`, sampled only on an input handshake.
- `in_valid` in, 1 / `in_ready` out, 1: input handshake.
- `in_data` in, 16: packed word; in FP8 modes the low byte is element 0 and the high byte is element 1.
- `in_last` in, 1: end-of-vector marker for the word.
- `out_valid` out, 1 / `out_ready` in, 1: output handshake.
- `out_sign` out, 1: element sign.
- `out_exp` out, 10 signed: unbiased exponent.
- `out_sig` out, 8: bit 7 is the hidden bit; bits 6:0 are the mantissa, left-aligned and zero-padded.
- `out_zero`, `out_inf`, `out_nan` out, 1 each: class flags, at most one set.
- `out_last` out, 1: last element of the vector.
- `elem_count` out, 16: count of output handshakes, wraps modulo 2^16.
- `nan_seen` out, 1: sticky; set when an element with `out_nan` is emitted.
- `mode_err` out, 1: sticky; set when a word is accepted with `mode` = 2'b11.

## Operation
- Output register (OR) holds one decoded element. `load_en = !out_valid || out_ready`.
- Pending register (P) holds the high byte, its mode and its `last` flag, with a `p_valid` bit.
- `in_ready = load_en && !p_valid` (combinational).
- Each cycle with `load_en`:
  - If `p_valid`: OR loads the decode of P, and `p_valid` clears.
  - Else if `in_valid`: the word is accepted.
    - BF16: OR loads the whole word with `out_last = in_last`.
    - FP8: OR loads the low byte with `out_last = 0`; P captures the high byte, `p_valid` sets, and P's `last` takes `in_last`.
  - Else: `out_valid` drops.
- Decode rules:
  - **E4M3:** bias 7. exp=0 means subnormal: `out_exp = -6`, hidden bit 0. exp=1111 with man=111 is NaN. There is no infinity; exp=1111 with man≠111 is a normal value.
  - **E5M2:** bias 15. exp=0 means subnormal: `out_exp = -14`. exp=11111 gives inf when man=0 and NaN otherwise.
  - **BF16:** bias 127. exp=0 means subnormal: `out_exp = -126`. exp=FF gives inf when man=0 and NaN otherwise. Subnormals are preserved, not flushed.
  - **Zero** (exp=0, man=0): `out_zero=1`, `out_exp=0`, `out_sig=0`, sign preserved.
  - **Inf/NaN:** `out_exp=0`, `out_sig=0`, sign preserved.
  - **`mode` = 2'b11:** the word is accepted as a single element with `out_nan=1`, `out_sign=0` and `out_last = in_last`. `mode_err` sets.
- `elem_count` increments on every `out_valid && out_ready`.
- `clear` zeroes `elem_count`, `nan_seen` and `mode_err`.
  - If `clear` coincides with an increment or a set event, `clear` wins for that cycle; the event is lost.

## Timing
- Reset values: `out_valid=0`, all `out_*` data and flags 0, `p_valid=0`, `elem_count=0`, `nan_seen=0`, `mode_err=0`.
  - `in_ready` reads 1 once `rst_n` is high.
  - Reset mid-stream discards both OR and P without emitting them.
- Latency: an element is valid on `out_*` in the cycle after it is accepted. The FP8 high byte is valid one cycle after the low byte when `out_ready` is held high.
- Throughput with `out_ready` held high:
  - BF16: 1 word/cycle.
  - FP8: 1 word per 2 cycles, 1 element per cycle; `in_ready` is low in every cycle P is full.
- Backpressure: while `out_valid && !out_ready`, all `out_*` are stable, and OR, P and `in_ready` are frozen (`in_ready=0`).
- `mode` may change on any accepted word; P decodes with its own captured mode.

## Structure
- Add to `fp_formats_pkg`:
  - `fp_unpacked_t` (sign, exp[9:0] signed, sig[7:0], zero, inf, nan).
  - Bias constants `E4M3_BIAS=7`, `E5M2_BIAS=15`, `BF16_BIAS=127`.
- Sub-module `fp_elem_decode`: purely combinational, with inputs (mode, raw[15:0]) and output `fp_unpacked_t`. FP8 input uses raw[7:0].
- Two instances of `fp_elem_decode`: one on the input word, one on P.
- The top level holds OR, P, the status counter and the sticky flags.

## Test plan
- **E4M3, word 0x7F38, `in_last=1`, `out_ready=1`:**
  - Cycle 1 output: sign 0, exp 0, sig 0x80, `last=0`.
  - Cycle 2 output: `out_nan=1`, `last=1`.
  - `in_ready` is 0 in cycle 1; `nan_seen=1`; `elem_count=2`.
- **E5M2, word 0x7C3C:** outputs are exp 0 / sig 0x80, then `out_inf=1`. E4M3, word 0x0001: outputs are exp −6 / sig 0x10, then `out_zero=1`.
- **BF16, words 0x3F80, 0x0001, 0xFF80 back-to-back, `out_ready=1`:**
  - Outputs in order: exp 0 / sig 0x80; exp −126 / sig 0x01; `out_inf=1` with sign 1.
  - One element per cycle; `in_ready` stays 1.
- **Backpressure:** FP8 word accepted, then `out_ready=0` for 5 cycles → outputs are stable, `in_ready=0`, and no element is lost or duplicated after release.
- **Sticky flags and boundaries:**
  - `mode`=2'b11 on word 0x1234 → one element with `out_nan=1`; `mode_err=1`.
  - `clear` in the same cycle as an output handshake → `elem_count=0`.
  - 65536 handshakes → `elem_count` wraps to 0.
- **Async reset** asserted while P is full → all outputs are 0 immediately; after release, no stale element appears.

Source files
------------

// File: rtl/fp_formats_pkg.sv
// Shared floating-point format definitions for the operand path.
// Holds the mode encoding, per-format exponent biases and the common
// unpacked element record handed to the systolic-array feeders.
package fp_formats_pkg;

   typedef enum logic [1:0] {
      MODE_E4M3 = 2'b00,
      MODE_E5M2 = 2'b01,
      MODE_BF16 = 2'b10,
      MODE_RSVD = 2'b11
   } fp_mode_e;

   localparam int E4M3_BIAS = 7;
   localparam int E5M2_BIAS = 15;
   localparam int BF16_BIAS = 127;

   typedef struct packed {
      logic              sign;
      logic signed [9:0] exp;
      logic [7:0]        sig;
      logic              zero;
      logic              inf;
      logic              nan;
   } fp_unpacked_t;

   // Two FP8 elements per packed word; everything else is one element.
   function automatic logic is_fp8(input fp_mode_e m);
      return (m == MODE_E4M3) || (m == MODE_E5M2);
   endfunction

endpackage

// File: rtl/fp_operand_unpack_if.sv
// Stream bundle between the operand SRAM read port and an edge feeder.
// slave  : the unpacker (consumes packed words, produces decoded elements)
// master : the environment driving words and accepting elements
interface fp_operand_unpack_if;
   import fp_formats_pkg::*;

   fp_mode_e          mode;
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       in_data;
   logic              in_last;

   logic              out_valid;
   logic              out_ready;
   logic              out_sign;
   logic signed [9:0] out_exp;
   logic [7:0]        out_sig;
   logic              out_zero;
   logic              out_inf;
   logic              out_nan;
   logic              out_last;

   modport slave (
      input  mode, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_sig,
             out_zero, out_inf, out_nan, out_last
   );

   modport master (
      output mode, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_sig,
             out_zero, out_inf, out_nan, out_last
   );

endinterface

// File: rtl/fp_elem_decode.sv
// Combinational decode of one element into unbiased sign/exp/significand
// plus class flags.
// Ports: mode - element format; raw - packed bits (FP8 uses raw[7:0]);
//        elem - decoded element.
module fp_elem_decode
   import fp_formats_pkg::*;
(
   input  fp_mode_e     mode,
   input  logic [15:0]  raw,
   output fp_unpacked_t elem
);

   always_comb begin
      elem = '0;
      case (mode)
         MODE_E4M3: begin
            elem.sign = raw[7];
            if (raw[6:0] == 7'h00) begin
               elem.zero = 1'b1;
            end else if (raw[6:0] == 7'h7f) begin
               // Only all-ones is NaN; E4M3 has no infinity encoding.
               elem.nan = 1'b1;
            end else if (raw[6:3] == 4'h0) begin
               elem.exp = 10'(1 - E4M3_BIAS);
               elem.sig = {1'b0, raw[2:0], 4'h0};
            end else begin
               elem.exp = 10'(raw[6:3]) - 10'(E4M3_BIAS);
               elem.sig = {1'b1, raw[2:0], 4'h0};
            end
         end
         MODE_E5M2: begin
            elem.sign = raw[7];
            if (raw[6:0] == 7'h00) begin
               elem.zero = 1'b1;
            end else if (raw[6:2] == 5'h1f) begin
               elem.inf = (raw[1:0] == 2'b00);
               elem.nan = (raw[1:0] != 2'b00);
            end else if (raw[6:2] == 5'h00) begin
               elem.exp = 10'(1 - E5M2_BIAS);
               elem.sig = {1'b0, raw[1:0], 5'h00};
            end else begin
               elem.exp = 10'(raw[6:2]) - 10'(E5M2_BIAS);
               elem.sig = {1'b1, raw[1:0], 5'h00};
            end
         end
         MODE_BF16: begin
            elem.sign = raw[15];
            if (raw[14:0] == 15'h0000) begin
               elem.zero = 1'b1;
            end else if (raw[14:7] == 8'hff) begin
               elem.inf = (raw[6:0] == 7'h00);
               elem.nan = (raw[6:0] != 7'h00);
            end else if (raw[14:7] == 8'h00) begin
               elem.exp = 10'(1 - BF16_BIAS);
               elem.sig = {1'b0, raw[6:0]};
            end else begin
               elem.exp = 10'(raw[14:7]) - 10'(BF16_BIAS);
               elem.sig = {1'b1, raw[6:0]};
            end
         end
         default: begin
            // Unsupported format: surface as a positive NaN so PEs poison it.
            elem.nan = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/fp_operand_unpack.sv
// Streaming operand unpacker: packed FP8x2 / BF16 words in, one decoded
// element per output handshake. One registered output stage (OR) and a
// one-element pending buffer (P) for the FP8 high byte.
// Ports: clk, rst_n (async, active-low); clear - synchronous clear of
//        elem_count/nan_seen/mode_err; bus - input/output streams;
//        elem_count - output handshake count; nan_seen, mode_err - sticky.
module fp_operand_unpack
   import fp_formats_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   fp_operand_unpack_if.slave        bus,
   output logic [15:0]               elem_count,
   output logic                      nan_seen,
   output logic                      mode_err
);

   fp_unpacked_t dec_in;
   fp_unpacked_t dec_p;
   fp_unpacked_t out_q;
   logic         out_valid_q;
   logic         out_last_q;
   logic         p_valid;
   logic         p_last;
   logic [7:0]   p_byte;
   fp_mode_e     p_mode;
   logic         load_en;
   logic         accept;
   logic         fire;

   fp_elem_decode u_dec_in (
      .mode (bus.mode),
      .raw  (bus.in_data),
      .elem (dec_in)
   );

   // P decodes with the mode captured alongside it, not the live mode.
   fp_elem_decode u_dec_p (
      .mode (p_mode),
      .raw  ({8'h00, p_byte}),
      .elem (dec_p)
   );

   assign load_en      = !out_valid_q || bus.out_ready;
   assign bus.in_ready = load_en && !p_valid;
   assign accept       = bus.in_valid && bus.in_ready;
   assign fire         = out_valid_q && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         p_valid     <= 1'b0;
         p_last      <= 1'b0;
         p_byte      <= 8'h00;
         p_mode      <= MODE_E4M3;
      end else if (load_en) begin
         if (p_valid) begin
            out_q       <= dec_p;
            out_last_q  <= p_last;
            out_valid_q <= 1'b1;
            p_valid     <= 1'b0;
         end else if (bus.in_valid) begin
            out_q       <= dec_in;
            out_valid_q <= 1'b1;
            if (is_fp8(bus.mode)) begin
               // The word's last flag travels with the high byte.
               out_last_q <= 1'b0;
               p_valid    <= 1'b1;
               p_byte     <= bus.in_data[15:8];
               p_mode     <= bus.mode;
               p_last     <= bus.in_last;
            end else begin
               out_last_q <= bus.in_last;
            end
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem_count <= 16'h0000;
         nan_seen   <= 1'b0;
         mode_err   <= 1'b0;
      end else if (clear) begin
         elem_count <= 16'h0000;
         nan_seen   <= 1'b0;
         mode_err   <= 1'b0;
      end else begin
         if (fire) begin
            elem_count <= elem_count + 16'h0001;
         end
         if (fire && out_q.nan) begin
            nan_seen <= 1'b1;
         end
         if (accept && (bus.mode == MODE_RSVD)) begin
            mode_err <= 1'b1;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_sign  = out_q.sign;
   assign bus.out_exp   = out_q.exp;
   assign bus.out_sig   = out_q.sig;
   assign bus.out_zero  = out_q.zero;
   assign bus.out_inf   = out_q.inf;
   assign bus.out_nan   = out_q.nan;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_fp_operand_unpack.sv
module tb_fp_operand_unpack;
   import fp_formats_pkg::*;

   typedef struct packed {
      logic       sign;
      logic [9:0] exp;
      logic [7:0] sig;
      logic       zero;
      logic       inf;
      logic       nan;
      logic       last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] elem_count;
   logic        nan_seen;
   logic        mode_err;

   fp_operand_unpack_if bus ();

   fp_operand_unpack dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .bus        (bus),
      .elem_count (elem_count),
      .nan_seen   (nan_seen),
      .mode_err   (mode_err)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   exp_t sbq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic exp_t el(input logic s, input logic [9:0] e, input logic [7:0] g,
                               input logic z, input logic i, input logic n, input logic l);
      exp_t r;
      r.sign = s; r.exp = e; r.sig = g; r.zero = z; r.inf = i; r.nan = n; r.last = l;
      return r;
   endfunction

   function automatic exp_t cur_out();
      exp_t r;
      r.sign = bus.out_sign; r.exp = bus.out_exp; r.sig = bus.out_sig;
      r.zero = bus.out_zero; r.inf = bus.out_inf; r.nan = bus.out_nan;
      r.last = bus.out_last;
      return r;
   endfunction

   // Monitor: pops the scoreboard on every output handshake.
   initial begin
      exp_t a;
      exp_t r;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && bus.out_valid && bus.out_ready) begin
            a = cur_out();
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_elem: got %h want none", a);
            end else begin
               r = sbq.pop_front();
               chk("elem", 32'(a), 32'(r));
            end
         end
      end
   end

   task automatic send(input logic [1:0] m, input logic [15:0] d, input logic l,
                       input exp_t e0, input exp_t e1, input bit two, output int waits);
      waits = 0;
      @(negedge clk);
      bus.mode     = fp_mode_e'(m);
      bus.in_data  = d;
      bus.in_last  = l;
      bus.in_valid = 1'b1;
      #1;
      while (!bus.in_ready && waits < 20) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (!bus.in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got in_ready 0 want 1 for word %h", d);
      end else begin
         sbq.push_back(e0);
         if (two) sbq.push_back(e1);
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 30) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("drain_left", sbq.size(), 0);
   endtask

   localparam exp_t Z = '0;

   initial begin
      int   w;
      exp_t snap;
      logic [15:0] cnt0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'h0000;
      bus.in_last   = 1'b0;
      bus.mode      = MODE_E4M3;
      bus.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", 32'(cur_out()), 32'(Z));
      chk("rst_count", elem_count, 0);
      chk("rst_sticky", {nan_seen, mode_err}, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);

      // E4M3 0x7F38: 1.0 then NaN
      send(2'b00, 16'h7F38, 1'b1, el(0, 10'd0, 8'h80, 0, 0, 0, 0),
           el(0, 10'd0, 8'h00, 0, 0, 1, 1), 1, w);
      idle();
      #1;
      chk("t1_in_ready_p_full", bus.in_ready, 0);
      repeat (2) @(negedge clk);
      #1;
      chk("t1_nan_seen", nan_seen, 1);
      chk("t1_count", elem_count, 2);

      // E5M2 0x7C3C: 1.0 then +inf; E4M3 0x0001: subnormal then zero
      send(2'b01, 16'h7C3C, 1'b0, el(0, 10'd0, 8'h80, 0, 0, 0, 0),
           el(0, 10'd0, 8'h00, 0, 1, 0, 0), 1, w);
      send(2'b00, 16'h0001, 1'b1, el(0, 10'h3FA, 8'h10, 0, 0, 0, 0),
           el(0, 10'd0, 8'h00, 1, 0, 0, 1), 1, w);
      idle();
      drain();

      // BF16 back-to-back
      send(2'b10, 16'h3F80, 1'b0, el(0, 10'd0, 8'h80, 0, 0, 0, 0), Z, 0, w);
      chk("bf16_w0_waits", w, 0);
      send(2'b10, 16'h0001, 1'b0, el(0, 10'h382, 8'h01, 0, 0, 0, 0), Z, 0, w);
      chk("bf16_w1_waits", w, 0);
      send(2'b10, 16'hFF80, 1'b1, el(1, 10'd0, 8'h00, 0, 1, 0, 1), Z, 0, w);
      chk("bf16_w2_waits", w, 0);
      idle();
      drain();

      // Backpressure: stall 5 cycles on the low byte
      cnt0 = elem_count;
      send(2'b01, 16'h7C3C, 1'b1, el(0, 10'd0, 8'h80, 0, 0, 0, 0),
           el(0, 10'd0, 8'h00, 0, 1, 0, 1), 1, w);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      snap = cur_out();
      chk("bp_snap", 32'(snap), 32'(el(0, 10'd0, 8'h80, 0, 0, 0, 0)));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("bp_stable", 32'(cur_out()), 32'(snap));
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      drain();
      @(negedge clk);
      #1;
      chk("bp_count", elem_count, cnt0 + 16'd2);

      // Reserved mode
      send(2'b11, 16'h1234, 1'b1, el(0, 10'd0, 8'h00, 0, 0, 1, 1), Z, 0, w);
      idle();
      drain();
      chk("rsvd_mode_err", mode_err, 1);

      // Clear coinciding with a NaN handshake: clear wins
      send(2'b11, 16'h1234, 1'b0, el(0, 10'd0, 8'h00, 0, 0, 1, 0), Z, 0, w);
      @(negedge clk);
      bus.in_valid = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      #1;
      chk("clr_count", elem_count, 0);
      chk("clr_nan_seen", nan_seen, 0);
      chk("clr_mode_err", mode_err, 0);
      drain();

      // Counter wrap
      for (int i = 0; i < 65535; i++)
         send(2'b10, 16'h3F80, 1'b0, el(0, 10'd0, 8'h80, 0, 0, 0, 0), Z, 0, w);
      idle();
      drain();
      chk("wrap_ffff", elem_count, 16'hFFFF);
      send(2'b10, 16'h4000, 1'b1, el(0, 10'd1, 8'h80, 0, 0, 0, 1), Z, 0, w);
      idle();
      drain();
      chk("wrap_zero", elem_count, 0);

      // Async reset with P full
      send(2'b00, 16'h7F38, 1'b0, el(0, 10'd0, 8'h80, 0, 0, 0, 0),
           el(0, 10'd0, 8'h00, 0, 0, 1, 0), 1, w);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_out_data", 32'(cur_out()), 32'(Z));
      chk("arst_in_ready", bus.in_ready, 1);
      sbq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("arst_no_stale", bus.out_valid, 0);
      end
      chk("arst_count", elem_count, 0);
      send(2'b10, 16'hFF80, 1'b1, el(1, 10'd0, 8'h00, 0, 1, 0, 1), Z, 0, w);
      idle();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
